// File: rtl/vga_game_pkg.sv
// Shared constants for the VGA game blocks: coordinate widths, screen geometry,
// sprite slot numbering and the frame scheduler state encoding.
package vga_game_pkg;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int SPR_PLAYER  = 0;
    localparam int SPR_ENEMY   = 1;
    localparam int SPR_BULLET  = 2;
    localparam int SPR_EBULLET = 3;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_COMMIT = 2'd1,
        ST_VBLANK = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sprite_frame_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the rotating pointer,
// and the pointer moves to the slot after the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_cand;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
        return PW'((int'(base) + off) % N);
    endfunction

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        w_cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = wrap(r_ptr, k);
            if (enable && req[w_cand]) begin
                grant         = '0;
                grant[w_cand] = 1'b1;
                grant_valid   = 1'b1;
                w_idx         = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (grant_valid)
            r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
    end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Buffers sprite position updates in shadow registers and copies them to the
// renderer-facing registers in a single cycle at vertical-blank start.
module sprite_frame_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int X_W         = vga_game_pkg::X_W,
    parameter int Y_W         = vga_game_pkg::Y_W,
    parameter int H_ACTIVE    = vga_game_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_game_pkg::V_ACTIVE
) (
    input  logic                       VGA_clk,
    input  logic                       reset,
    input  logic [9:0]                 xCount,
    input  logic [9:0]                 yCount,
    input  logic                       freeze,
    input  logic [NUM_SPRITES-1:0]     req,
    input  logic [NUM_SPRITES*X_W-1:0] req_x,
    input  logic [NUM_SPRITES*Y_W-1:0] req_y,
    output logic [NUM_SPRITES-1:0]     ack,
    output logic [NUM_SPRITES-1:0]     pending,
    output logic [NUM_SPRITES-1:0]     sprite_valid,
    output logic [NUM_SPRITES*X_W-1:0] sprite_x,
    output logic [NUM_SPRITES*Y_W-1:0] sprite_y,
    output logic                       frame_commit
);

    import vga_game_pkg::*;

    sched_state_e r_state, w_state_nxt;

    logic [NUM_SPRITES-1:0]          r_ack, r_pending, r_valid;
    logic [NUM_SPRITES-1:0][X_W-1:0] r_shadow_x, r_active_x;
    logic [NUM_SPRITES-1:0][Y_W-1:0] r_shadow_y, r_active_y;
    logic [NUM_SPRITES-1:0][X_W-1:0] w_req_x;
    logic [NUM_SPRITES-1:0][Y_W-1:0] w_req_y;
    logic [NUM_SPRITES-1:0]          w_grant;
    logic                            w_grant_valid;
    logic                            w_commit;

    assign w_req_x  = req_x;
    assign w_req_y  = req_y;
    assign w_commit = (r_state == ST_COMMIT);

    // A sprite being acked this cycle is masked so it cannot win twice.
    rr_arbiter #(.N(NUM_SPRITES)) u_arb (
        .clk         (VGA_clk),
        .rst         (reset),
        .req         (req & ~r_ack),
        .enable      (!freeze),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset)
            r_state <= ST_ACTIVE;
        else
            r_state <= w_state_nxt;
    end

    // A vblank missed while frozen is simply skipped, not deferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACTIVE: if (xCount == 10'd0 && yCount == 10'(V_ACTIVE) && !freeze)
                           w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_VBLANK;
            ST_VBLANK: if (xCount == 10'd0 && yCount == 10'd0)
                           w_state_nxt = ST_ACTIVE;
            default:   w_state_nxt = ST_ACTIVE;
        endcase
    end

    // Commit reads the pre-write shadow; a same-cycle grant keeps pending set.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_ack      <= '0;
            r_pending  <= '0;
            r_valid    <= '0;
            r_shadow_x <= '0;
            r_shadow_y <= '0;
            r_active_x <= '0;
            r_active_y <= '0;
        end else begin
            r_ack <= w_grant;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_grant[i]) begin
                    r_shadow_x[i] <= w_req_x[i];
                    r_shadow_y[i] <= w_req_y[i];
                end
                if (w_commit && r_pending[i]) begin
                    r_active_x[i] <= r_shadow_x[i];
                    r_active_y[i] <= r_shadow_y[i];
                    r_valid[i]    <= 1'b1;
                end
                if (w_grant[i])
                    r_pending[i] <= 1'b1;
                else if (w_commit)
                    r_pending[i] <= 1'b0;
            end
        end
    end

    assign ack          = r_ack;
    assign pending      = r_pending;
    assign sprite_valid = r_valid;
    assign sprite_x     = r_active_x;
    assign sprite_y     = r_active_y;
    assign frame_commit = w_commit;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: handshake, round-robin order,
// vblank commit timing, freeze and reset behaviour.
module tb_sprite_frame_scheduler;

    logic        VGA_clk;
    logic        reset;
    logic [9:0]  xCount, yCount;
    logic        freeze;
    logic [3:0]  req;
    logic [39:0] req_x;
    logic [35:0] req_y;
    logic [3:0]  ack, pending, sprite_valid;
    logic [39:0] sprite_x;
    logic [35:0] sprite_y;
    logic        frame_commit;

    int n_assert = 0;
    int n_fail   = 0;

    sprite_frame_scheduler dut (
        .VGA_clk      (VGA_clk),
        .reset        (reset),
        .xCount       (xCount),
        .yCount       (yCount),
        .freeze       (freeze),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .ack          (ack),
        .pending      (pending),
        .sprite_valid (sprite_valid),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .frame_commit (frame_commit)
    );

    initial VGA_clk = 1'b0;
    always #5 VGA_clk = ~VGA_clk;

    function automatic logic [39:0] px(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [35:0] py(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic tick();
        @(posedge VGA_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk through vblank start, commit cycle, vblank and back to active video.
    task automatic go_commit(input string tag);
        xCount = 10'd0; yCount = 10'd480;
        tick();
        chk({tag, "_fc_hi"}, 64'(frame_commit), 64'd1);
        xCount = 10'd1;
        tick();
        chk({tag, "_fc_lo"}, 64'(frame_commit), 64'd0);
        xCount = 10'd0; yCount = 10'd0;
        tick();
        xCount = 10'd5; yCount = 10'd10;
    endtask

    initial begin
        reset  = 1'b1;
        xCount = 10'd5;
        yCount = 10'd10;
        freeze = 1'b0;
        req    = 4'b0000;
        req_x  = '0;
        req_y  = '0;
        tick(); tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_valid", 64'(sprite_valid), 64'd0);
        chk("rst_x", 64'(sprite_x), 64'd0);
        chk("rst_y", 64'(sprite_y), 64'd0);
        chk("rst_fc", 64'(frame_commit), 64'd0);
        reset = 1'b0;
        tick();

        // Round-robin with all four requesting, requesters dropping after ack
        req_x = px(11, 22, 33, 44);
        req_y = py(1, 2, 3, 4);
        req = 4'b1111; tick(); chk("rr_ack0", 64'(ack), 64'b0001);
        req = 4'b1110; tick(); chk("rr_ack1", 64'(ack), 64'b0010);
        req = 4'b1100; tick(); chk("rr_ack2", 64'(ack), 64'b0100);
        req = 4'b1000; tick(); chk("rr_ack3", 64'(ack), 64'b1000);
        req = 4'b0000; tick(); chk("rr_idle", 64'(ack), 64'd0);
        req = 4'b1001; tick(); chk("rr2_ack0", 64'(ack), 64'b0001);
        req = 4'b1000; tick(); chk("rr2_ack3", 64'(ack), 64'b1000);
        req = 4'b0000; tick();
        chk("rr_pending", 64'(pending), 64'b1111);
        chk("rr_x_held", 64'(sprite_x), 64'd0);

        // Single write held in shadow until vblank
        req_x[9:0] = 10'd100;
        req_y[8:0] = 9'd200;
        req = 4'b0001; tick();
        chk("t1_ack", 64'(ack), 64'b0001);
        chk("t1_pending", 64'(pending), 64'b1111);
        chk("t1_x_held", 64'(sprite_x), 64'd0);
        req = 4'b0000; tick();
        chk("t1_ack_drop", 64'(ack), 64'd0);
        xCount = 10'd0; yCount = 10'd480;
        tick();
        chk("t1_fc", 64'(frame_commit), 64'd1);
        chk("t1_x_in_commit", 64'(sprite_x), 64'd0);
        xCount = 10'd1;
        tick();
        chk("t1_x", 64'(sprite_x), 64'(px(100, 22, 33, 44)));
        chk("t1_y", 64'(sprite_y), 64'(py(200, 2, 3, 4)));
        chk("t1_valid", 64'(sprite_valid), 64'b1111);
        chk("t1_pending_clr", 64'(pending), 64'd0);
        chk("t1_fc_lo", 64'(frame_commit), 64'd0);
        xCount = 10'd0; yCount = 10'd0; tick();
        xCount = 10'd5; yCount = 10'd10;

        // Grant landing in the commit cycle itself
        req_x[29:20] = 10'd250;
        req = 4'b0100; tick(); chk("t3_ack_a", 64'(ack), 64'b0100);
        req = 4'b0000; tick();
        xCount = 10'd0; yCount = 10'd480;
        tick();
        chk("t3_fc", 64'(frame_commit), 64'd1);
        req_x[29:20] = 10'd300;
        req = 4'b0100;
        tick();
        chk("t3_x_old", 64'(sprite_x), 64'(px(100, 22, 250, 44)));
        chk("t3_pending", 64'(pending), 64'b0100);
        chk("t3_ack_b", 64'(ack), 64'b0100);
        req = 4'b0000;
        xCount = 10'd1; tick();
        xCount = 10'd0; yCount = 10'd0; tick();
        xCount = 10'd5; yCount = 10'd10;
        go_commit("t3_next");
        chk("t3_x_new", 64'(sprite_x), 64'(px(100, 22, 300, 44)));
        chk("t3_pending_clr", 64'(pending), 64'd0);

        // Freeze across a vblank
        req_x[19:10] = 10'd77;
        req = 4'b0010; tick(); chk("t4_ack1", 64'(ack), 64'b0010);
        req = 4'b0000; tick();
        freeze = 1'b1;
        req_x[9:0] = 10'd5;
        req = 4'b0001;
        xCount = 10'd0; yCount = 10'd480;
        tick();
        chk("t4_fc_frz", 64'(frame_commit), 64'd0);
        chk("t4_ack_frz", 64'(ack), 64'd0);
        tick();
        chk("t4_ack_frz2", 64'(ack), 64'd0);
        chk("t4_x_held", 64'(sprite_x), 64'(px(100, 22, 300, 44)));
        chk("t4_pending", 64'(pending), 64'b0010);
        freeze = 1'b0;
        xCount = 10'd1;
        tick();
        chk("t4_fc_skip", 64'(frame_commit), 64'd0);
        chk("t4_ack_unfrz", 64'(ack), 64'b0001);
        req = 4'b0000;
        xCount = 10'd5; yCount = 10'd10; tick();
        go_commit("t4_next");
        chk("t4_x", 64'(sprite_x), 64'(px(5, 77, 300, 44)));

        // Asynchronous reset with a request outstanding
        req = 4'b0101; tick(); chk("t5_ack2", 64'(ack), 64'b0100);
        req = 4'b0001; tick(); chk("t5_ack0", 64'(ack), 64'b0001);
        req = 4'b0000; tick();
        chk("t5_pending", 64'(pending), 64'b0101);
        req_x[39:30] = 10'd600;
        req_y[35:27] = 9'd400;
        req = 4'b1000;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ack", 64'(ack), 64'd0);
        chk("t5_pending0", 64'(pending), 64'd0);
        chk("t5_valid", 64'(sprite_valid), 64'd0);
        chk("t5_x", 64'(sprite_x), 64'd0);
        chk("t5_y", 64'(sprite_y), 64'd0);
        chk("t5_fc", 64'(frame_commit), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_reack", 64'(ack), 64'b1000);
        req = 4'b0000; tick();

        // Two writes to one sprite within a frame; only the last is shown
        req_x[9:0] = 10'd10;
        req = 4'b0001; tick(); chk("t6_ack_a", 64'(ack), 64'b0001);
        req = 4'b0000; tick();
        req_x[9:0] = 10'd20;
        req = 4'b0001; tick(); chk("t6_ack_b", 64'(ack), 64'b0001);
        req = 4'b0000; tick();
        chk("t6_valid_pre", 64'(sprite_valid), 64'd0);
        chk("t6_pending", 64'(pending), 64'b1001);
        go_commit("t6");
        chk("t6_x", 64'(sprite_x), 64'(px(20, 0, 0, 600)));
        chk("t6_y", 64'(sprite_y), 64'(py(200, 0, 0, 400)));
        chk("t6_valid", 64'(sprite_valid), 64'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
